// File: rtl/fir_capture_buffer.sv
// fir_capture_buffer
// Captures a triggered window of DEPTH signed filter-output samples into
// on-chip RAM, then replays the window over a valid/ready stream.
//
// Optional feature macro: CAP_LEVEL_TRIG_EN
//   When defined, parameter TRIG_LEVEL is added. A rising crossing of the
//   input through TRIG_LEVEL also counts as a trigger, ORed with the
//   trigger port.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   sample_in    signed sample to capture (DATA_W)
//   sample_valid sample_in qualifier
//   arm          request to arm a capture (honoured only in IDLE)
//   trigger      external trigger, qualified by sample_valid
//   abort        return to IDLE on the next edge; wins over all other inputs
//   rd_data      playback sample (DATA_W)
//   rd_valid     rd_data valid
//   rd_ready     downstream accepts rd_data
//   rd_last      asserted with the final word (index DEPTH-1)
//   busy         state is not IDLE
//   done         one-cycle pulse after the last word is accepted
//   count        samples written in the current window (ADDR_W)
module fir_capture_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 400,
  parameter int ADDR_W = 9
`ifdef CAP_LEVEL_TRIG_EN
  ,
  parameter logic signed [DATA_W-1:0] TRIG_LEVEL = {DATA_W{1'b0}}
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              arm,
  input  logic              trigger,
  input  logic              abort,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_r [0:(1<<ADDR_W)-1];

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] count_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              prime_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r;
  logic              rd_last_r;
  logic              busy_r;
  logic              done_r;

  logic              trig_ev_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic              fetch_s;
  logic              last_acc_s;
  logic              arm_ok_s;

`ifdef CAP_LEVEL_TRIG_EN
  logic signed [DATA_W-1:0] prev_r;
  logic                     cross_s;

  // Previous valid sample, tracked in every state; starts at the most negative value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= {1'b1, {(DATA_W-1){1'b0}}};
    end else if (sample_valid) begin
      prev_r <= $signed(sample_in);
    end
  end

  assign cross_s   = sample_valid && (prev_r < TRIG_LEVEL) && ($signed(sample_in) >= TRIG_LEVEL);
  assign trig_ev_s = sample_valid && (trigger || cross_s);
`else
  assign trig_ev_s = sample_valid && trigger;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt_s = state_r;
    wr_en_s     = 1'b0;
    wr_addr_s   = count_r;
    fetch_s     = 1'b0;
    last_acc_s  = 1'b0;
    arm_ok_s    = 1'b0;
    if (abort) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (arm) begin
            arm_ok_s    = 1'b1;
            state_nxt_s = ARMED;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        ARMED: begin
          if (trig_ev_s) begin
            wr_en_s     = 1'b1;
            wr_addr_s   = {ADDR_W{1'b0}};
            state_nxt_s = CAPTURE;
          end else begin
            state_nxt_s = ARMED;
          end
        end
        CAPTURE: begin
          if (sample_valid) begin
            wr_en_s = 1'b1;
            if (count_r == LAST_ADDR) begin
              state_nxt_s = DRAIN;
            end else begin
              state_nxt_s = CAPTURE;
            end
          end else begin
            state_nxt_s = CAPTURE;
          end
        end
        DRAIN: begin
          // The first fetch waits one idle cycle (prime_r) so the first word
          // appears two clocks after the final write.
          if (rd_valid_r && rd_ready && rd_last_r) begin
            last_acc_s  = 1'b1;
            state_nxt_s = IDLE;
          end else if ((prime_r && !rd_valid_r) || (rd_valid_r && rd_ready)) begin
            fetch_s = 1'b1;
          end else begin
            fetch_s = 1'b0;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // Capture RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= sample_in;
    end
  end

  // Counters, registered read port and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r    <= {ADDR_W{1'b0}};
      rd_addr_r  <= {ADDR_W{1'b0}};
      prime_r    <= 1'b0;
      rd_data_r  <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r  <= last_acc_s;
      busy_r  <= (state_nxt_s != IDLE);
      prime_r <= (state_r == DRAIN) && (state_nxt_s == DRAIN);
      if (arm_ok_s) begin
        count_r <= {ADDR_W{1'b0}};
      end else if (wr_en_s) begin
        count_r <= wr_addr_s + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      // Outside DRAIN the read side is idle; count is kept for debug.
      if (state_nxt_s != DRAIN) begin
        rd_valid_r <= 1'b0;
        rd_last_r  <= 1'b0;
        rd_addr_r  <= {ADDR_W{1'b0}};
      end else if (fetch_s) begin
        rd_data_r  <= mem_r[rd_addr_r];
        rd_valid_r <= 1'b1;
        rd_last_r  <= (rd_addr_r == LAST_ADDR);
        if (rd_addr_r != LAST_ADDR) begin
          rd_addr_r <= rd_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign rd_last  = rd_last_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign count    = count_r;

endmodule
